// File: rtl/dmem_resp.sv
// dmem_resp: responder end of the CPU data-memory bus.
// Serves load/store requests from an internal word-organised RAM with byte/half/word lane
// steering, sign/zero extension and WAIT_CYCLES programmable wait states.
// Optional feature: define DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses as errors.
module dmem_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_resp: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Latched request payload (data path, no reset needed)
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic        access;
  logic        mis;
  logic        mem_we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [4:0]  sh;
  logic [31:0] rd_word;

  // Upper address bits alias onto the same RAM; they are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:DEPTH_LOG2+2];

  // Right-justified byte/half extended to 32 bits; word passes through.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic u);
    case (sz)
      2'b00:   return u ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   return u ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign idx    = addr_q[DEPTH_LOG2+1:2];
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef DMEM_MISALIGN_ERR_EN
  assign mis = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign mem_we  = access && we_q && !mis;
  assign rd_word = mem[idx];

  // Lane steering: byte enables, replicated store data and load shift amount
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    sh = 5'd0;
    case (size_q)
      2'b00: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
        sh = {addr_q[1:0], 3'b000};
      end
      2'b01: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
        sh = {addr_q[1], 4'b0000};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
        sh = 5'd0;
      end
    endcase
  end

  // RAM write on the access edge, only the selected lanes
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Next-state, counter, payload capture and response data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = size;
          uns_d   = uns;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (mis) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else begin
            err_d = 1'b0;
            if (!we_q) rdata_d = extend(rd_word >> sh, size_q, uns_q);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers, asynchronously reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Payload registers
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
  end

  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: instance 0 has no wait states, instance 1 has three.
module tb_dmem_resp;

  logic clk;
  logic rstn;
  logic [1:0]       req, we, uns, ack, err, busy;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][1:0]  size;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rstn(rstn), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .size(size[0]), .uns(uns[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
  );

  dmem_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rstn(rstn), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .size(size[1]), .uns(uns[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction on instance d; returns response data, err and ack latency (0 = timeout).
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic u,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; size[d] = sz; uns[d] = u;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ack[d] === 1'b1) begin
        lat = k;
        break;
      end
    end
    rd = rdata[d];
    er = err[d];
    req[d] = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req = '0; we = '0; uns = '0; addr = '0; wdata = '0; size = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ack, err, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ack/err/busy=%b required 000000", {ack, err, busy});
    end
    n_checks++;
    if (rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h required 0/0", rdata[0], rdata[1]);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL word_store_lat: got %0d required 1", lat); end
    txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL word_load_lat: got %0d required 1", lat); end
    n_checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL word_load: got %h err %b required deadbeef err 0", rd, er);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h13, 32'h80, 2'b00, 1'b0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL store_keeps_rdata: got %h required deadbeef", rd);
    end
    txn(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_sext: got %h required ffffff80", rd); end
    txn(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00000080) begin n_fail++; $display("FAIL byte_zext: got %h required 00000080", rd); end
    txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL byte_merge: got %h required 80adbeef", rd); end
    txn(0, 1'b0, 32'h1010, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL addr_alias: got %h required 80adbeef", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h14, 32'h11223344, 2'b10, 1'b0, rd, er, lat);
    txn(0, 1'b1, 32'h16, 32'h00008001, 2'b01, 1'b0, rd, er, lat);
    txn(0, 1'b0, 32'h16, 32'h0, 2'b01, 1'b0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL half_sext: got %h required ffff8001", rd); end
    txn(0, 1'b0, 32'h16, 32'h0, 2'b01, 1'b1, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00008001) begin n_fail++; $display("FAIL half_zext: got %h required 00008001", rd); end
    txn(0, 1'b0, 32'h14, 32'h0, 2'b01, 1'b1, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00003344) begin n_fail++; $display("FAIL half_low_kept: got %h required 00003344", rd); end
    txn(0, 1'b0, 32'h14, 32'h0, 2'b11, 1'b0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h80013344) begin n_fail++; $display("FAIL half_word_view: got %h required 80013344", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    logic [10:0] ackv, busyv;
    txn(1, 1'b1, 32'h20, 32'hA5A5A5A5, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL wait_store_lat: got %0d required 4", lat); end
    // Hold req high across the ack: second ack only after a fresh IDLE acceptance.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20; size[1] = 2'b10; uns[1] = 1'b0;
    @(posedge clk); #1;
    ackv[0] = ack[1]; busyv[0] = busy[1];
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      ackv[k] = ack[1]; busyv[k] = busy[1];
    end
    rd = rdata[1];
    req[1] = 1'b0;
    @(posedge clk);
    n_checks++;
    if (ackv !== 11'b10000010000) begin
      n_fail++; $display("FAIL wait_ack_pattern: got %b required 10000010000", ackv);
    end
    n_checks++;
    if (busyv !== 11'b11111011111) begin
      n_fail++; $display("FAIL wait_busy_pattern: got %b required 11111011111", busyv);
    end
    n_checks++;
    if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wait_load: got %h required a5a5a5a5", rd); end
    // Payload changes after acceptance must not affect the access.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20; size[1] = 2'b10; uns[1] = 1'b0;
    @(posedge clk); #1;
    addr[1] = 32'h23; size[1] = 2'b00; uns[1] = 1'b1; wdata[1] = 32'h0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ack[1] === 1'b1) begin lat = k; break; end
    end
    rd = rdata[1];
    req[1] = 1'b0;
    @(posedge clk);
    n_checks++;
    if (rd !== 32'hA5A5A5A5 || lat !== 4) begin
      n_fail++; $display("FAIL latched_payload: got %h lat %0d required a5a5a5a5 lat 4", rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    int stray_acks;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h55; size[1] = 2'b10; uns[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({ack[1], err[1], busy[1]} !== 3'b000 || rdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ack/err/busy=%b rdata=%h required 000 0",
               {ack[1], err[1], busy[1]}, rdata[1]);
    end
    req[1] = 1'b0;
    stray_acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack[1] !== 1'b0) stray_acks++;
    end
    n_checks++;
    if (stray_acks !== 0) begin n_fail++; $display("FAIL mid_reset_ack: got %0d acks required 0", stray_acks); end
    @(negedge clk);
    rstn = 1'b1;
    txn(1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hA5A5A5A5 || lat !== 4) begin
      n_fail++; $display("FAIL mid_reset_ram: got %h lat %0d required a5a5a5a5 lat 4", rd, lat);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
`ifdef DMEM_MISALIGN_ERR_EN
    txn(0, 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      n_fail++; $display("FAIL mis_word_load: err %b rdata %h lat %0d required 1 0 1", er, rd, lat);
    end
    txn(0, 1'b1, 32'h11, 32'h12345678, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL mis_word_store: err %b required 1", er); end
    txn(0, 1'b0, 32'h13, 32'h0, 2'b01, 1'b1, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL mis_half_load: err %b rdata %h required 1 0", er, rd);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h80ADBEEF) begin
      n_fail++; $display("FAIL mis_ram_kept: err %b rdata %h required 0 80adbeef", er, rd);
    end
`else
    txn(0, 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, rd, er, lat);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h80ADBEEF || lat !== 1) begin
      n_fail++; $display("FAIL trunc_word_load: err %b rdata %h lat %0d required 0 80adbeef 1", er, rd, lat);
    end
    txn(0, 1'b0, 32'h13, 32'h0, 2'b01, 1'b1, rd, er, lat);
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h000080AD) begin
      n_fail++; $display("FAIL trunc_half_load: err %b rdata %h required 0 000080ad", er, rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wait_states();
    test_reset_mid();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
